// File: rtl/itcm_arb.sv
// itcm_arb: shares the single ITCM SRAM port between auto-load, AHB debug,
// core data port and instruction fetch. It grants one access per cycle,
// remembers who owns the outstanding read, and promotes fetch after it has
// been denied for too long.
module itcm_arb #(
    parameter int          ADDR_WIDTH      = 32,
    parameter int          DATA_WIDTH      = 32,
    parameter logic [31:0] ITCM_START_ADDR = 32'h0000_0000,
    parameter logic [31:0] ITCM_SIZE       = 32'h8000,
    parameter int          WORD_AW         = 13,
    parameter int          STARVE_LIMIT    = 4,
    parameter int          STARVE_W        = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  al_active,
    input  logic                  al_req,
    input  logic [ADDR_WIDTH-1:0] al_addr,
    input  logic [DATA_WIDTH-1:0] al_wdata,
    output logic                  al_ready,

    input  logic                  ahb_req,
    input  logic                  ahb_we,
    input  logic [3:0]            ahb_be,
    input  logic [ADDR_WIDTH-1:0] ahb_addr,
    input  logic [DATA_WIDTH-1:0] ahb_wdata,
    output logic                  ahb_ready,
    output logic                  ahb_rvalid,
    output logic                  ahb_err,

    input  logic                  dat_req,
    input  logic                  dat_we,
    input  logic [3:0]            dat_be,
    input  logic [ADDR_WIDTH-1:0] dat_addr,
    input  logic [DATA_WIDTH-1:0] dat_wdata,
    output logic                  dat_ready,
    output logic                  dat_rvalid,

    input  logic                  ifu_req,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_ready,
    output logic                  ifu_rvalid,

    output logic [DATA_WIDTH-1:0] rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [WORD_AW-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] START_A   = ADDR_WIDTH'(ITCM_START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] SIZE_A    = ADDR_WIDTH'(ITCM_SIZE);
    localparam logic [STARVE_W-1:0]   LIMIT_C   = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0]   ONE_C     = STARVE_W'(1);

    logic [STARVE_W-1:0]   starve_cnt;
    logic                  promote;
    logic                  ahb_oor;
    logic                  g_al;
    logic                  g_ahb;
    logic                  g_dat;
    logic                  g_ifu;
    logic [ADDR_WIDTH-1:0] sel_addr;

    assign promote = (starve_cnt == LIMIT_C);
    assign ahb_oor = ((ahb_addr - START_A) >= SIZE_A);

    // Fixed-priority grant; auto-load always wins, fetch jumps ahead of AHB/data once starved
    always_comb begin
        g_al  = 1'b0;
        g_ahb = 1'b0;
        g_dat = 1'b0;
        g_ifu = 1'b0;
        if (!rst) begin
            if (al_req) begin
                g_al = 1'b1;
            end else if (!al_active) begin
                if (promote) begin
                    if (ifu_req)      g_ifu = 1'b1;
                    else if (ahb_req) g_ahb = 1'b1;
                    else if (dat_req) g_dat = 1'b1;
                end else begin
                    if (ahb_req)      g_ahb = 1'b1;
                    else if (dat_req) g_dat = 1'b1;
                    else if (ifu_req) g_ifu = 1'b1;
                end
            end
        end
    end

    // Steer the winning requester onto the SRAM port; fetch is always a full-word read
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'hf;
        sel_addr  = ifu_addr;
        mem_wdata = al_wdata;
        if (g_al) begin
            mem_we    = 1'b1;
            mem_be    = 4'hf;
            sel_addr  = al_addr;
            mem_wdata = al_wdata;
        end else if (g_ahb) begin
            mem_we    = ahb_we;
            mem_be    = ahb_be;
            sel_addr  = ahb_addr;
            mem_wdata = ahb_wdata;
        end else if (g_dat) begin
            mem_we    = dat_we;
            mem_be    = dat_be;
            sel_addr  = dat_addr;
            mem_wdata = dat_wdata;
        end
    end

    assign mem_addr  = WORD_AW'((sel_addr - START_A) >> 2);
    assign mem_en    = g_al | g_dat | g_ifu | (g_ahb & ~ahb_oor);
    assign al_ready  = g_al;
    assign ahb_ready = g_ahb;
    assign dat_ready = g_dat;
    assign ifu_ready = g_ifu;
    assign rdata     = mem_rdata;

    // Track read ownership, AHB range errors and fetch starvation
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            ahb_rvalid <= 1'b0;
            dat_rvalid <= 1'b0;
            ifu_rvalid <= 1'b0;
            ahb_err    <= 1'b0;
        end else begin
            ahb_rvalid <= g_ahb & ~ahb_we & ~ahb_oor;
            dat_rvalid <= g_dat & ~dat_we;
            ifu_rvalid <= g_ifu;
            ahb_err    <= g_ahb & ahb_oor;
            if (!al_active) begin
                if (ifu_req && !g_ifu) begin
                    if (starve_cnt < LIMIT_C) starve_cnt <= starve_cnt + ONE_C;
                end else begin
                    starve_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_itcm_arb.sv
// tb_itcm_arb: table-driven bench for itcm_arb with a behavioural SRAM
// (1-cycle read latency, write lands at the grant edge).
module tb_itcm_arb;

    logic        clk;
    logic        rst;
    logic        al_active, al_req;
    logic [31:0] al_addr, al_wdata;
    logic        al_ready;
    logic        ahb_req, ahb_we;
    logic [3:0]  ahb_be;
    logic [31:0] ahb_addr, ahb_wdata;
    logic        ahb_ready, ahb_rvalid, ahb_err;
    logic        dat_req, dat_we;
    logic [3:0]  dat_be;
    logic [31:0] dat_addr, dat_wdata;
    logic        dat_ready, dat_rvalid;
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_ready, ifu_rvalid;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] sram [8192];

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        rst, act, alr;
        logic [31:0] al_addr;
        logic        ahbr, ahbw;
        logic [31:0] ahb_addr;
        logic        datr, datw;
        logic [3:0]  be;
        logic [31:0] dat_addr;
        logic        ifur;
        logic [31:0] ifu_addr;
        logic [31:0] wdata;
        logic [3:0]  e_rdy;
        logic        e_en, e_we;
        logic [3:0]  e_be;
        logic [12:0] e_addr;
        logic [2:0]  e_rv;
        logic        e_err;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [22];

    itcm_arb dut (
        .clk(clk), .rst(rst),
        .al_active(al_active), .al_req(al_req), .al_addr(al_addr),
        .al_wdata(al_wdata), .al_ready(al_ready),
        .ahb_req(ahb_req), .ahb_we(ahb_we), .ahb_be(ahb_be),
        .ahb_addr(ahb_addr), .ahb_wdata(ahb_wdata),
        .ahb_ready(ahb_ready), .ahb_rvalid(ahb_rvalid), .ahb_err(ahb_err),
        .dat_req(dat_req), .dat_we(dat_we), .dat_be(dat_be),
        .dat_addr(dat_addr), .dat_wdata(dat_wdata),
        .dat_ready(dat_ready), .dat_rvalid(dat_rvalid),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr),
        .ifu_ready(ifu_ready), .ifu_rvalid(ifu_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: byte-masked write at the edge, registered read data
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    function automatic vec_t mk_in(logic r, logic act, logic alr, logic [31:0] ala,
                                   logic ahbr, logic ahbw, logic [31:0] ahba,
                                   logic datr, logic datw, logic [3:0] be, logic [31:0] data,
                                   logic ifur, logic [31:0] ifua, logic [31:0] wd);
        vec_t v;
        v.rst = r; v.act = act; v.alr = alr; v.al_addr = ala;
        v.ahbr = ahbr; v.ahbw = ahbw; v.ahb_addr = ahba;
        v.datr = datr; v.datw = datw; v.be = be; v.dat_addr = data;
        v.ifur = ifur; v.ifu_addr = ifua; v.wdata = wd;
        v.e_rdy = '0; v.e_en = 1'b0; v.e_we = 1'b0; v.e_be = 4'hf; v.e_addr = '0;
        v.e_rv = '0; v.e_err = 1'b0; v.chk_rd = 1'b0; v.e_rd = '0;
        return v;
    endfunction

    function automatic vec_t with_exp(vec_t vi, logic [3:0] rdy, logic en, logic we,
                                      logic [3:0] ebe, logic [12:0] eaddr, logic [2:0] rv,
                                      logic err, logic chkrd, logic [31:0] rd);
        vec_t v;
        v = vi;
        v.e_rdy = rdy; v.e_en = en; v.e_we = we; v.e_be = ebe; v.e_addr = eaddr;
        v.e_rv = rv; v.e_err = err; v.chk_rd = chkrd; v.e_rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        al_active = v.act;
        al_req    = v.alr;
        al_addr   = v.al_addr;
        al_wdata  = v.wdata;
        ahb_req   = v.ahbr;
        ahb_we    = v.ahbw;
        ahb_be    = v.be;
        ahb_addr  = v.ahb_addr;
        ahb_wdata = v.wdata;
        dat_req   = v.datr;
        dat_we    = v.datw;
        dat_be    = v.be;
        dat_addr  = v.dat_addr;
        dat_wdata = v.wdata;
        ifu_req   = v.ifur;
        ifu_addr  = v.ifu_addr;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        #2;
        chk({tag, " ready"}, {28'd0, al_ready, ahb_ready, dat_ready, ifu_ready}, {28'd0, v.e_rdy});
        chk({tag, " mem_en"}, {31'd0, mem_en}, {31'd0, v.e_en});
        if (v.e_en) begin
            chk({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, v.e_we});
            chk({tag, " mem_be"}, {28'd0, mem_be}, {28'd0, v.e_be});
            chk({tag, " mem_addr"}, {19'd0, mem_addr}, {19'd0, v.e_addr});
            if (v.e_we) chk({tag, " mem_wdata"}, mem_wdata, v.wdata);
        end
        @(posedge clk);
        #1;
        chk({tag, " rvalid"}, {29'd0, ahb_rvalid, dat_rvalid, ifu_rvalid}, {29'd0, v.e_rv});
        chk({tag, " ahb_err"}, {31'd0, ahb_err}, {31'd0, v.e_err});
        if (v.chk_rd) chk({tag, " rdata"}, rdata, v.e_rd);
    endtask

    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v);
        checkOutput(v, tag);
    endtask

    vec_t starve_in, rst_starve_in, al_starve_in;
    vec_t v_ahb, v_ifu, v_al;

    initial begin
        for (int i = 0; i < 8192; i++) sram[i] = 32'h1000_0000 + i;
        sram[4] = 32'hDEAD_BEEF;
        mem_rdata = '0;

        tbl[0]  = with_exp(mk_in(1,0,1,32'h0, 1,0,32'h10, 1,0,4'hf,32'h20, 1,32'hC, 32'h0), 4'b0000,0,0,4'hf,13'd0, 3'b000,0,0,32'h0);
        tbl[1]  = tbl[0];
        tbl[2]  = with_exp(mk_in(0,0,0,32'h0, 1,0,32'h10, 1,0,4'hf,32'h20, 1,32'hC, 32'h0), 4'b0100,1,0,4'hf,13'd4, 3'b100,0,1,32'hDEAD_BEEF);
        tbl[3]  = with_exp(mk_in(0,0,0,32'h0, 0,0,32'h10, 1,0,4'hf,32'h20, 1,32'hC, 32'h0), 4'b0010,1,0,4'hf,13'd8, 3'b010,0,1,32'h1000_0008);
        tbl[4]  = with_exp(mk_in(0,0,0,32'h0, 0,0,32'h0, 0,0,4'hf,32'h0, 0,32'h0, 32'h0), 4'b0000,0,0,4'hf,13'd0, 3'b000,0,0,32'h0);
        for (int i = 5; i <= 8; i++)
            tbl[i] = with_exp(mk_in(0,0,0,32'h0, 1,0,32'h10, 0,0,4'hf,32'h0, 1,32'hC, 32'h0), 4'b0100,1,0,4'hf,13'd4, 3'b100,0,1,32'hDEAD_BEEF);
        tbl[9]  = with_exp(mk_in(0,0,0,32'h0, 1,0,32'h10, 0,0,4'hf,32'h0, 1,32'hC, 32'h0), 4'b0001,1,0,4'hf,13'd3, 3'b001,0,1,32'h1000_0003);
        tbl[10] = tbl[5];
        tbl[11] = tbl[4];
        tbl[12] = with_exp(mk_in(0,1,1,32'h0, 1,0,32'h10, 0,0,4'hf,32'h0, 1,32'h0, 32'h1234_5678), 4'b1000,1,1,4'hf,13'd0, 3'b000,0,0,32'h0);
        tbl[13] = with_exp(mk_in(0,1,0,32'h0, 1,0,32'h10, 0,0,4'hf,32'h0, 1,32'h0, 32'h0), 4'b0000,0,0,4'hf,13'd0, 3'b000,0,0,32'h0);
        tbl[14] = with_exp(mk_in(0,0,0,32'h0, 0,0,32'h0, 0,0,4'hf,32'h0, 1,32'h0, 32'h0), 4'b0001,1,0,4'hf,13'd0, 3'b001,0,1,32'h1234_5678);
        tbl[15] = with_exp(mk_in(0,0,0,32'h0, 1,1,32'h8000, 0,0,4'hf,32'h0, 0,32'h0, 32'hFFFF_FFFF), 4'b0100,0,0,4'hf,13'd0, 3'b000,1,0,32'h0);
        tbl[16] = with_exp(mk_in(0,0,0,32'h0, 1,0,32'h0, 0,0,4'hf,32'h0, 0,32'h0, 32'h0), 4'b0100,1,0,4'hf,13'd0, 3'b100,0,1,32'h1234_5678);
        tbl[17] = with_exp(mk_in(0,0,1,32'h8, 1,0,32'h8, 0,0,4'hf,32'h0, 0,32'h0, 32'hCAFE_F00D), 4'b1000,1,1,4'hf,13'd2, 3'b000,0,0,32'h0);
        tbl[18] = with_exp(mk_in(0,0,0,32'h0, 1,0,32'h8, 0,0,4'hf,32'h0, 0,32'h0, 32'h0), 4'b0100,1,0,4'hf,13'd2, 3'b100,0,1,32'hCAFE_F00D);
        tbl[19] = with_exp(mk_in(0,0,0,32'h0, 0,0,32'h0, 1,1,4'h3,32'h24, 0,32'h0, 32'hAABB_CCDD), 4'b0010,1,1,4'h3,13'd9, 3'b000,0,0,32'h0);
        tbl[20] = with_exp(mk_in(0,0,0,32'h0, 0,0,32'h0, 1,0,4'hf,32'h24, 0,32'h0, 32'h0), 4'b0010,1,0,4'hf,13'd9, 3'b010,0,1,32'h1000_CCDD);
        tbl[21] = with_exp(mk_in(0,0,0,32'h0, 0,0,32'h0, 1,0,4'hf,32'h8024, 0,32'h0, 32'h0), 4'b0010,1,0,4'hf,13'd9, 3'b010,0,1,32'h1000_CCDD);

        for (int i = 0; i < 22; i++) runVec(tbl[i], $sformatf("vec%0d", i));

        // Reset clears a saturated starvation count: AHB wins again right after reset
        starve_in     = mk_in(0,0,0,32'h190, 1,0,32'h10, 0,0,4'hf,32'h0, 1,32'hC, 32'h0);
        v_ahb         = with_exp(starve_in, 4'b0100,1,0,4'hf,13'd4, 3'b100,0,1,32'hDEAD_BEEF);
        v_ifu         = with_exp(starve_in, 4'b0001,1,0,4'hf,13'd3, 3'b001,0,1,32'h1000_0003);
        rst_starve_in = starve_in;
        rst_starve_in.rst = 1'b1;
        for (int i = 0; i < 4; i++) runVec(v_ahb, $sformatf("rst_seq%0d", i));
        runVec(with_exp(rst_starve_in, 4'b0000,0,0,4'hf,13'd0, 3'b000,0,0,32'h0), "rst_seq_reset");
        runVec(v_ahb, "rst_seq_after");
        runVec(tbl[4], "rst_seq_idle");

        // Auto-load beats a promoted fetch; the count stays saturated so fetch wins next
        al_starve_in = mk_in(0,0,1,32'h190, 1,0,32'h10, 0,0,4'hf,32'h0, 1,32'hC, 32'h5555_AAAA);
        v_al         = with_exp(al_starve_in, 4'b1000,1,1,4'hf,13'd100, 3'b000,0,0,32'h0);
        for (int i = 0; i < 4; i++) runVec(v_ahb, $sformatf("al_seq%0d", i));
        runVec(v_al, "al_seq_al");
        runVec(v_ifu, "al_seq_ifu");
        runVec(v_ahb, "al_seq_ahb");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
